// File: rtl/bp_pkg.sv
// bp_pkg: shared counter encodings, PC step and index extraction for BTB and direction predictor
package bp_pkg;
  localparam logic [1:0] SNT = 2'b00;
  localparam logic [1:0] WNT = 2'b01;
  localparam logic [1:0] WT = 2'b10;
  localparam logic [1:0] ST = 2'b11;
  localparam logic [31:0] PC_STEP = 32'd4;
  function automatic logic [29:0] bp_index(input logic [31:0] pc);
    return pc[31:2];
  endfunction
endpackage

// File: rtl/branch_dir_predictor_if.sv
// branch_dir_predictor_if: lookup, update and prediction signals of the direction predictor
interface branch_dir_predictor_if #(parameter int STAT_W = 32) ();
  logic lookup_valid;
  logic [31:0] lookup_pc;
  logic [31:0] btb_target;
  logic upd_valid;
  logic [31:0] upd_pc;
  logic upd_taken;
  logic upd_mispred;
  logic pred_valid;
  logic pred_taken;
  logic [31:0] next_pc;
  logic [STAT_W-1:0] stat_branches;
  logic [STAT_W-1:0] stat_mispred;
  modport master (
    output lookup_valid, lookup_pc, btb_target, upd_valid, upd_pc, upd_taken, upd_mispred,
    input pred_valid, pred_taken, next_pc, stat_branches, stat_mispred
  );
  modport slave (
    input lookup_valid, lookup_pc, btb_target, upd_valid, upd_pc, upd_taken, upd_mispred,
    output pred_valid, pred_taken, next_pc, stat_branches, stat_mispred
  );
endinterface

// File: rtl/branch_dir_predictor_sat_counter2.sv
// sat_counter2: next state of a 2-bit saturating direction counter
module sat_counter2
  import bp_pkg::*;
(
  input logic [1:0] cur,
  input logic taken,
  output logic [1:0] nxt
);
  assign nxt = taken ? (cur == ST ? ST : cur + 2'd1) : (cur == SNT ? SNT : cur - 2'd1);
endmodule

// File: rtl/branch_dir_predictor.sv
// branch_dir_predictor: 2-bit counter direction predictor selecting BTB target or PC+4
module branch_dir_predictor
  import bp_pkg::*;
#(
  parameter int IDX_BITS = 10,
  parameter logic [1:0] CNT_INIT = WNT,
  parameter int STAT_W = 32
) (
  input logic clk,
  input logic rst,
  branch_dir_predictor_if.slave bus
);
  localparam int DEPTH = 2 ** IDX_BITS;
  logic [1:0] cnt_q [DEPTH];
  logic [1:0] cnt_d [DEPTH];
  logic pv_q, pv_d, pt_q, pt_d;
  logic [31:0] pc_q, pc_d;
  logic [STAT_W-1:0] sb_q, sb_d, sm_q, sm_d;
  logic [IDX_BITS-1:0] lk_idx, upd_idx;
  logic [1:0] upd_next;
  assign lk_idx = IDX_BITS'(bp_index(bus.lookup_pc));
  assign upd_idx = IDX_BITS'(bp_index(bus.upd_pc));
  sat_counter2 u_sat (.cur(cnt_q[upd_idx]), .taken(bus.upd_taken), .nxt(upd_next));
  always_comb begin
    cnt_d = cnt_q;
    if (bus.upd_valid) cnt_d[upd_idx] = upd_next;
    pv_d = bus.lookup_valid;
    pt_d = bus.lookup_valid ? cnt_d[lk_idx][1] : pt_q;
    pc_d = bus.lookup_valid ? bus.lookup_pc : pc_q;
    sb_d = (bus.upd_valid && !(&sb_q)) ? sb_q + STAT_W'(1) : sb_q;
    sm_d = (bus.upd_valid && bus.upd_mispred && !(&sm_q)) ? sm_q + STAT_W'(1) : sm_q;
  end
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      cnt_q <= '{default: CNT_INIT};
      pv_q <= 1'b0;
      pt_q <= 1'b0;
      pc_q <= '0 - PC_STEP;
      sb_q <= '0;
      sm_q <= '0;
    end else begin
      cnt_q <= cnt_d;
      pv_q <= pv_d;
      pt_q <= pt_d;
      pc_q <= pc_d;
      sb_q <= sb_d;
      sm_q <= sm_d;
    end
  end
  assign bus.pred_valid = pv_q;
  assign bus.pred_taken = pt_q;
  assign bus.next_pc = (pv_q && pt_q) ? bus.btb_target : pc_q + PC_STEP;
  assign bus.stat_branches = sb_q;
  assign bus.stat_mispred = sm_q;
endmodule

// File: tb/tb_branch_dir_predictor.sv
// tb_branch_dir_predictor: directed and random checks against a behavioural predictor model
module tb_branch_dir_predictor;
  localparam int SW = 4;
  localparam int SMAX = (1 << SW) - 1;
  logic clk = 1'b0;
  logic rst = 1'b0;
  int checks = 0;
  int errors = 0;
  int m_cnt [1024];
  bit m_pv;
  bit m_pt;
  logic [31:0] m_fall;
  int m_sb;
  int m_sm;
  branch_dir_predictor_if #(.STAT_W(SW)) bus ();
  branch_dir_predictor #(.STAT_W(SW)) dut (.clk(clk), .rst(rst), .bus(bus));
  always #5 clk = ~clk;
  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask
  function automatic int midx(input logic [31:0] pc);
    return int'((pc / 4) % 1024);
  endfunction
  task automatic model_reset();
    for (int i = 0; i < 1024; i++) m_cnt[i] = 1;
    m_pv = 0;
    m_pt = 0;
    m_fall = 32'h0;
    m_sb = 0;
    m_sm = 0;
  endtask
  task automatic check_all(input string tag);
    chk({tag, ".pv"}, {31'h0, bus.pred_valid}, {31'h0, m_pv});
    chk({tag, ".pt"}, {31'h0, bus.pred_taken}, {31'h0, m_pt});
    chk({tag, ".npc"}, bus.next_pc, (m_pv && m_pt) ? bus.btb_target : m_fall);
    chk({tag, ".sb"}, 32'(bus.stat_branches), 32'(m_sb));
    chk({tag, ".sm"}, 32'(bus.stat_mispred), 32'(m_sm));
  endtask
  task automatic step(input string tag, input bit lv, input logic [31:0] lpc, input logic [31:0] bt,
                      input bit uv, input logic [31:0] upc, input bit ut, input bit um);
    @(negedge clk);
    bus.lookup_valid = lv;
    bus.lookup_pc = lpc;
    bus.btb_target = bt;
    bus.upd_valid = uv;
    bus.upd_pc = upc;
    bus.upd_taken = ut;
    bus.upd_mispred = um;
    @(posedge clk);
    if (uv) begin
      m_cnt[midx(upc)] = ut ? (m_cnt[midx(upc)] == 3 ? 3 : m_cnt[midx(upc)] + 1)
                            : (m_cnt[midx(upc)] == 0 ? 0 : m_cnt[midx(upc)] - 1);
      m_sb = m_sb == SMAX ? SMAX : m_sb + 1;
      m_sm = (um && m_sm < SMAX) ? m_sm + 1 : m_sm;
    end
    m_pv = lv;
    if (lv) begin
      m_pt = m_cnt[midx(lpc)] >= 2;
      m_fall = lpc + 32'd4;
    end
    #1;
    check_all(tag);
  endtask
  task automatic upd(input logic [31:0] pc, input bit t, input bit m);
    step("upd", 0, 32'h0, 32'h0, 1, pc, t, m);
  endtask
  task automatic look(input logic [31:0] pc, input logic [31:0] bt);
    step("look", 1, pc, bt, 0, 32'h0, 0, 0);
  endtask
  initial begin
    bus.lookup_valid = 0;
    bus.lookup_pc = 0;
    bus.btb_target = 0;
    bus.upd_valid = 0;
    bus.upd_pc = 0;
    bus.upd_taken = 0;
    bus.upd_mispred = 0;
    model_reset();
    repeat (2) @(negedge clk);
    check_all("reset");
    chk("reset.npc0", bus.next_pc, 32'h0);
    rst = 1'b1;
    look(32'h100, 32'h800);
    chk("first.npc", bus.next_pc, 32'h104);
    upd(32'h100, 1, 0);
    upd(32'h100, 1, 0);
    look(32'h100, 32'h800);
    chk("taken.npc", bus.next_pc, 32'h800);
    upd(32'h100, 1, 0);
    upd(32'h100, 1, 0);
    upd(32'h100, 0, 1);
    look(32'h100, 32'h800);
    chk("st_hyst.pt", {31'h0, bus.pred_taken}, 32'h1);
    for (int i = 0; i < 5; i++) upd(32'h200, 0, 0);
    look(32'h200, 32'h900);
    chk("snt.pt", {31'h0, bus.pred_taken}, 32'h0);
    upd(32'h200, 1, 0);
    look(32'h200, 32'h900);
    chk("snt_wnt.pt", {31'h0, bus.pred_taken}, 32'h0);
    step("bypass", 1, 32'h300, 32'hA00, 1, 32'h300, 1, 0);
    chk("bypass.npc", bus.next_pc, 32'hA00);
    look(32'h1300, 32'hB00);
    chk("alias.pt", {31'h0, bus.pred_taken}, 32'h1);
    look(32'hFFFFFFFC, 32'h1234);
    chk("wrap.npc", bus.next_pc, 32'h0);
    step("idle", 0, 32'h0, 32'h1234, 0, 32'h0, 0, 0);
    chk("idle.pv", {31'h0, bus.pred_valid}, 32'h0);
    @(negedge clk);
    rst = 1'b0;
    model_reset();
    @(negedge clk);
    rst = 1'b1;
    for (int i = 0; i < 10; i++) upd(32'h400 + 32'(i * 4), i[0], i < 3);
    chk("stat.sb10", 32'(bus.stat_branches), 32'd10);
    chk("stat.sm3", 32'(bus.stat_mispred), 32'd3);
    for (int i = 0; i < 8; i++) upd(32'h500, 1, 1);
    chk("stat.sat", 32'(bus.stat_branches), 32'(SMAX));
    for (int i = 0; i < 300; i++)
      step("rand", 1'($urandom), 32'($urandom_range(0, 3) << 12) | 32'($urandom_range(0, 7) << 2), $urandom,
           1'($urandom), 32'($urandom_range(0, 3) << 12) | 32'($urandom_range(0, 7) << 2),
           1'($urandom), 1'($urandom));
    for (int i = 0; i < 3; i++) upd(32'h700, 1, 0);
    step("pre_rst", 1, 32'h104, 32'h2000, 0, 32'h0, 0, 0);
    @(posedge clk);
    #2;
    rst = 1'b0;
    model_reset();
    #1;
    chk("arst.pv", {31'h0, bus.pred_valid}, 32'h0);
    chk("arst.pt", {31'h0, bus.pred_taken}, 32'h0);
    chk("arst.npc", bus.next_pc, 32'h0);
    chk("arst.sb", 32'(bus.stat_branches), 32'h0);
    chk("arst.sm", 32'(bus.stat_mispred), 32'h0);
    @(negedge clk);
    rst = 1'b1;
    look(32'h700, 32'h3000);
    chk("arst.wnt", {31'h0, bus.pred_taken}, 32'h0);
    upd(32'h700, 1, 0);
    look(32'h700, 32'h3000);
    chk("arst.wt", bus.next_pc, 32'h3000);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule

// File: doc/branch_dir_predictor.md
Name: branch_dir_predictor

Overview:
- Direction-prediction stage directly downstream of the direct-mapped BTB.
- Holds a table of 2-bit saturating counters indexed by PC[11:2] and registers a taken/not-taken prediction. The prediction aligns with the BTB's registered target one cycle after lookup.
- Selects the final next-fetch PC: the BTB target when taken, otherwise PC+4.
- Trained by branch resolution from execute; keeps saturating branch and mispredict statistics.

Parameters:
- IDX_BITS, 10, counter-table index width; table depth is 2**IDX_BITS, index is pc[IDX_BITS+1:2].
- CNT_INIT, 2'b01, counter value loaded at reset (weakly not-taken).
- STAT_W, 32, width of the statistics counters.

Ports:
- clk  in  1  clock, rising edge.
- rst  in  1  reset, asynchronous, active-low.
- lookup_valid  in  1  fetch presents a PC this cycle.
- lookup_pc  in  32  fetch PC; the same value the BTB receives as currentPC.
- btb_target  in  32  BTB registered target, valid the cycle after lookup.
- upd_valid  in  1  resolved branch from execute.
- upd_pc  in  32  PC of the resolved branch.
- upd_taken  in  1  actual branch outcome.
- upd_mispred  in  1  execute detected a direction or target mispredict.
- pred_valid  out  1  next_pc and pred_taken are meaningful.
- pred_taken  out  1  registered direction prediction.
- next_pc  out  32  selected next fetch PC.
- stat_branches  out  STAT_W  resolved-branch count.
- stat_mispred  out  STAT_W  mispredict count.

Behaviour:
- Reset (rst low, asynchronous):
  - all counters = CNT_INIT;
  - pred_valid = 0, pred_taken = 0, next_pc = 0;
  - stat_branches = 0, stat_mispred = 0.
  - Reset asserted mid-operation discards any in-flight lookup or update.
- Lookup, latency 1:
  - On a cycle with lookup_valid = 1, register pc_q = lookup_pc, pred_valid = 1, pred_taken = cnt[idx][1].
  - On a cycle with lookup_valid = 0, pred_valid = 0 next cycle; pc_q and pred_taken hold.
- next_pc is combinational from registered state and btb_target:
  - pred_valid & pred_taken: btb_target;
  - otherwise: pc_q + 4, modulo 2^32 (0xFFFFFFFC wraps to 0x00000000).
- Update, effective the cycle after upd_valid:
  - upd_taken = 1: counter increments, saturating at 2'b11.
  - upd_taken = 0: counter decrements, saturating at 2'b00.
- Counter transitions: 00<->01<->10<->11 only. No wrap-around is permitted.
- Lookup/update collision: same index in the same cycle. The lookup bypasses and uses the post-update counter value (the write-first view).
- Aliasing: different PCs with the same index share a counter. No tag check is made.
- Statistics, on each upd_valid:
  - stat_branches += 1;
  - stat_mispred += upd_mispred.
  - Both saturate at all-ones and never wrap.
- The block never stalls: no ready/backpressure. One lookup and one update are accepted per cycle.

Decomposition:
- Shared package bp_pkg holds:
  - counter encodings SNT = 2'b00, WNT = 2'b01, WT = 2'b10, ST = 2'b11;
  - PC_STEP = 32'd4;
  - the index-extraction function, shared with the BTB so both index identically.
- One natural sub-module: sat_counter2. It is a pure combinational next-state function (current value, taken) -> next value, instantiated once on the update path.
- The table and statistics stay in the top module.

Test Plan:
- Reset, then lookup pc=0x00000100 with btb_target=0x00000800 -> next cycle pred_valid=1, pred_taken=0, next_pc=0x00000104.
- Two updates taken at pc=0x100, then lookup 0x100 with btb_target=0x800 -> pred_taken=1, next_pc=0x00000800. Two more taken updates keep the counter at ST; a single not-taken update still predicts taken.
- Five not-taken updates at 0x200 from reset -> counter held at SNT, no wrap. One taken update -> WNT, still predicts not-taken.
- Same-cycle update (taken, counter WNT) and lookup at 0x300 -> prediction taken (bypass). Lookup 0x1300, which aliases 0x300, also predicts taken.
- Lookup pc=0xFFFFFFFC, counter not-taken -> next_pc=0x00000000. Lookup_valid low for one cycle -> pred_valid=0.
- Ten updates with three upd_mispred -> stat_branches=10, stat_mispred=3.
- Preload stat_branches near all-ones (STAT_W forced small in the bench) -> it holds at all-ones.
- Assert rst asynchronously mid-stream -> all outputs zero immediately, counters back to WNT.
